// File: rtl/ecb_pkg.sv
// Shared types for the bit-serial ECB feeder and its matching downstream collector.
package ecb_pkg;

    localparam int BLOCK_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/ecb_bit_feeder.sv
// Upstream stage of the bit-serial ECB encryptor: takes whole plaintext blocks and streams
// block and key bits, one per transfer, into the 1-bit XOR encryptor with first/last framing.
//
// state | meaning
// IDLE  | no block in flight; accepts a block once a key is loaded
// SHIFT | presenting bit idx of the latched block/key; advances on bit_ready
module ecb_bit_feeder
    import ecb_pkg::*;
#(
    parameter int BLOCK_W   = BLOCK_W_DEF,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] key_in,
    input  logic               key_load,
    output logic               key_valid,
    input  logic [BLOCK_W-1:0] pt_in,
    input  logic               pt_valid,
    output logic               pt_ready,
    output logic               pt_bit,
    output logic               k_bit,
    output logic               bit_valid,
    input  logic               bit_ready,
    output logic               bit_first,
    output logic               bit_last,
    output logic               busy,
    output logic [CNT_W-1:0]   blk_count
);

    localparam int IDX_W = $clog2(BLOCK_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_W - 1);

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic               key_valid_q, key_valid_d;
    logic [BLOCK_W-1:0] pt_sr_q, pt_sr_d;
    logic [BLOCK_W-1:0] k_sr_q, k_sr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   blk_count_q, blk_count_d;

    logic [IDX_W-1:0]   sel;
    logic               shifting;
    logic               at_last;
    logic               xfer;
    logic               accept;

    always_comb begin
        shifting = (state_q == SHIFT);
        at_last  = shifting && (idx_q == LAST_IDX);
        xfer     = shifting && bit_ready;
        pt_ready = key_valid_q && (!shifting || (at_last && bit_ready));
        accept   = pt_valid && pt_ready;
        sel      = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
    end

    // idx parks on the last position after a block ends, so pt_bit/k_bit keep showing the
    // last transferred bit while idle without a separate holding register.
    assign pt_bit    = pt_sr_q[sel];
    assign k_bit     = k_sr_q[sel];
    assign bit_valid = shifting;
    assign bit_first = shifting && (idx_q == '0);
    assign bit_last  = at_last;
    assign busy      = shifting;
    assign key_valid = key_valid_q;
    assign blk_count = blk_count_q;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        pt_sr_d     = pt_sr_q;
        k_sr_d      = k_sr_q;
        idx_d       = idx_q;
        blk_count_d = blk_count_q;

        // A same-cycle load lands in key_q only; the block below snapshots the old key_q.
        if (key_load) begin
            key_d       = key_in;
            key_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    pt_sr_d = pt_in;
                    k_sr_d  = key_q;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        blk_count_d = blk_count_q + 1'b1;
                        if (accept) begin
                            pt_sr_d = pt_in;
                            k_sr_d  = key_q;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            pt_sr_q     <= '0;
            k_sr_q      <= '0;
            idx_q       <= '0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            pt_sr_q     <= pt_sr_d;
            k_sr_q      <= k_sr_d;
            idx_q       <= idx_d;
            blk_count_q <= blk_count_d;
        end
    end

endmodule

// File: tb/tb_ecb_bit_feeder.sv
// Self-checking bench for ecb_bit_feeder: directed scenarios plus a randomized run
// checked against a beat-queue reference model.
module tb_ecb_bit_feeder;

    localparam int BW   = ecb_pkg::BLOCK_W_DEF;
    localparam bit MSBF = 1'b1;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] key_in;
    logic          key_load;
    logic          key_valid;
    logic [BW-1:0] pt_in;
    logic          pt_valid;
    logic          pt_ready;
    logic          pt_bit;
    logic          k_bit;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_first;
    logic          bit_last;
    logic          busy;
    logic [CW-1:0] blk_count;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [BW-1:0] cur_key;
    int            exp_cnt;

    ecb_bit_feeder #(.BLOCK_W(BW), .MSB_FIRST(MSBF), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_valid(key_valid),
        .pt_in(pt_in), .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_bit(pt_bit), .k_bit(k_bit),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_first(bit_first), .bit_last(bit_last),
        .busy(busy), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    // Bit position of beat number b within a block.
    function automatic int bit_pos(input int b);
        return MSBF ? (BW - 1 - b) : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_in = '0; key_load = 1'b0; pt_in = '0; pt_valid = 1'b0; bit_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bit_valid !== 1'b0) $display("FAIL reset_bit_valid: got %b expected 0", bit_valid); else n_pass++;
        n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (blk_count !== '0) $display("FAIL reset_blk_count: got %0d expected 0", blk_count); else n_pass++;
        n_checks++; if ({pt_bit, k_bit, bit_first, bit_last} !== 4'b0000)
            $display("FAIL reset_bits: got %b expected 0000", {pt_bit, k_bit, bit_first, bit_last}); else n_pass++;
        n_checks++; if (pt_ready !== 1'b0) $display("FAIL reset_pt_ready: got %b expected 0", pt_ready); else n_pass++;
        exp_cnt = 0;
    endtask

    task automatic test_no_key();
        int bad;
        bad = 0;
        pt_in = 8'hA5; pt_valid = 1'b1; bit_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pt_ready !== 1'b0 || bit_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL no_key_ignored: got %0d bad cycles expected 0", bad); else n_pass++;
        n_checks++; if (blk_count !== '0) $display("FAIL no_key_count: got %0d expected 0", blk_count); else n_pass++;
        key_in = 8'h3C; key_load = 1'b1;
        #1;
        n_checks++; if (pt_ready !== 1'b0) $display("FAIL key_load_cycle_ready: got %b expected 0", pt_ready); else n_pass++;
        tick();
        key_load = 1'b0;
        #1;
        n_checks++; if (key_valid !== 1'b1) $display("FAIL key_valid_set: got %b expected 1", key_valid); else n_pass++;
        n_checks++; if (pt_ready !== 1'b1) $display("FAIL key_loaded_ready: got %b expected 1", pt_ready); else n_pass++;
        cur_key = 8'h3C;
    endtask

    // Continues from test_no_key: pt_valid is still high with A5 and the feeder is ready.
    task automatic test_single_block();
        logic [BW-1:0] pt_w, k_w, first_m, last_m;
        int bad;
        bad = 0;
        tick();
        pt_valid = 1'b0;
        #1;
        for (int b = 0; b < BW; b++) begin
            if (bit_valid !== 1'b1) bad++;
            pt_w[bit_pos(b)] = pt_bit;
            k_w[bit_pos(b)]  = k_bit;
            first_m[b]       = bit_first;
            last_m[b]        = bit_last;
            tick();
        end
        n_checks++; if (bad != 0) $display("FAIL single_valid: got %0d gaps expected 0", bad); else n_pass++;
        n_checks++; if (pt_w !== 8'hA5) $display("FAIL single_pt_stream: got %h expected a5", pt_w); else n_pass++;
        n_checks++; if (k_w !== 8'h3C) $display("FAIL single_k_stream: got %h expected 3c", k_w); else n_pass++;
        n_checks++; if ((pt_w ^ k_w) !== 8'h99) $display("FAIL single_xor: got %h expected 99", pt_w ^ k_w); else n_pass++;
        n_checks++; if (first_m !== 8'h01) $display("FAIL single_first: got %b expected 00000001", first_m); else n_pass++;
        n_checks++; if (last_m !== 8'h80) $display("FAIL single_last: got %b expected 10000000", last_m); else n_pass++;
        n_checks++; if (blk_count !== CW'(1)) $display("FAIL single_count: got %0d expected 1", blk_count); else n_pass++;
        n_checks++; if (bit_valid !== 1'b0) $display("FAIL single_idle_after: got %b expected 0", bit_valid); else n_pass++;
        exp_cnt = 1;
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] w0, w1;
        logic [15:0]   ready_m;
        int gaps;
        gaps = 0;
        pt_in = 8'h00; pt_valid = 1'b1; bit_ready = 1'b1;
        tick();
        pt_in = 8'hFF;
        for (int b = 0; b < 2 * BW; b++) begin
            if (b == BW) pt_valid = 1'b0;
            #1;
            if (bit_valid !== 1'b1) gaps++;
            if (b < BW) w0[bit_pos(b)] = pt_bit;
            else        w1[bit_pos(b - BW)] = pt_bit;
            ready_m[b] = pt_ready;
            tick();
        end
        exp_cnt += 2;
        n_checks++; if (gaps != 0) $display("FAIL b2b_gaps: got %0d expected 0", gaps); else n_pass++;
        n_checks++; if (w0 !== 8'h00) $display("FAIL b2b_block0: got %h expected 00", w0); else n_pass++;
        n_checks++; if (w1 !== 8'hFF) $display("FAIL b2b_block1: got %h expected ff", w1); else n_pass++;
        n_checks++; if (ready_m !== 16'h8080) $display("FAIL b2b_ready_pulses: got %h expected 8080", ready_m); else n_pass++;
        n_checks++; if (blk_count !== CW'(exp_cnt)) $display("FAIL b2b_count: got %0d expected %0d", blk_count, exp_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_after: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] pt, pt_w, k_w;
        logic [3:0]    pat, cur, prev;
        logic          stalled;
        int t, c, unstable, frame_bad, cnt_bad, bad;
        pat = 4'b1001;
        t = 0; c = 0; unstable = 0; frame_bad = 0; cnt_bad = 0; bad = 0;
        stalled = 1'b0; prev = '0;
        pt = BW'($urandom);
        pt_in = pt; pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        while (t < BW && c < 64) begin
            bit_ready = pat[c % 4];
            #1;
            cur = {pt_bit, k_bit, bit_first, bit_last};
            if (stalled && cur !== prev) unstable++;
            if (bit_valid !== 1'b1) bad++;
            if (blk_count !== CW'(exp_cnt)) cnt_bad++;
            if (bit_ready) begin
                pt_w[bit_pos(t)] = pt_bit;
                k_w[bit_pos(t)]  = k_bit;
                if (bit_first !== (t == 0)) frame_bad++;
                if (bit_last !== (t == BW - 1)) frame_bad++;
                t++;
            end
            stalled = !bit_ready;
            prev = cur;
            c++;
            tick();
        end
        bit_ready = 1'b1;
        exp_cnt++;
        n_checks++; if (t != BW) $display("FAIL bp_timeout: got %0d transfers expected %0d", t, BW); else n_pass++;
        n_checks++; if (unstable != 0) $display("FAIL bp_stable: got %0d changes while stalled expected 0", unstable); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL bp_valid: got %0d gaps expected 0", bad); else n_pass++;
        n_checks++; if (frame_bad != 0) $display("FAIL bp_framing: got %0d errors expected 0", frame_bad); else n_pass++;
        n_checks++; if (cnt_bad != 0) $display("FAIL bp_early_count: got %0d early cycles expected 0", cnt_bad); else n_pass++;
        n_checks++; if (pt_w !== pt) $display("FAIL bp_pt_stream: got %h expected %h", pt_w, pt); else n_pass++;
        n_checks++; if (k_w !== cur_key) $display("FAIL bp_k_stream: got %h expected %h", k_w, cur_key); else n_pass++;
        n_checks++; if (blk_count !== CW'(exp_cnt)) $display("FAIL bp_count: got %0d expected %0d", blk_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_key_reload();
        logic [BW-1:0] pt_a, pt_b, pa_w, ka_w, pb_w, kb_w;
        pt_a = BW'($urandom);
        pt_b = BW'($urandom);
        bit_ready = 1'b1;
        pt_in = pt_a; pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        for (int b = 0; b < BW; b++) begin
            if (b == 3) begin key_in = 8'hF0; key_load = 1'b1; end
            if (b == 4) key_load = 1'b0;
            #1;
            pa_w[bit_pos(b)] = pt_bit;
            ka_w[bit_pos(b)] = k_bit;
            tick();
        end
        pt_in = pt_b; pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        for (int b = 0; b < BW; b++) begin
            #1;
            pb_w[bit_pos(b)] = pt_bit;
            kb_w[bit_pos(b)] = k_bit;
            tick();
        end
        exp_cnt += 2;
        n_checks++; if (ka_w !== cur_key) $display("FAIL reload_old_key: got %h expected %h", ka_w, cur_key); else n_pass++;
        n_checks++; if (pa_w !== pt_a) $display("FAIL reload_pt_a: got %h expected %h", pa_w, pt_a); else n_pass++;
        n_checks++; if (kb_w !== 8'hF0) $display("FAIL reload_new_key: got %h expected f0", kb_w); else n_pass++;
        n_checks++; if (pb_w !== pt_b) $display("FAIL reload_pt_b: got %h expected %h", pb_w, pt_b); else n_pass++;
        n_checks++; if (blk_count !== CW'(exp_cnt)) $display("FAIL reload_count: got %0d expected %0d", blk_count, exp_cnt); else n_pass++;
        cur_key = 8'hF0;
    endtask

    // Reference: a block becomes a queue of BW expected beats; the head beat is what must be on
    // the bus, popping the last beat counts a block, and a block is accepted when the queue is
    // empty or is about to empty this cycle.
    task automatic test_random();
        logic [3:0]    beat_q[$];
        logic [BW-1:0] key_m;
        logic [5:0]    obs, expv;
        logic          exp_valid, exp_ready;
        int cnt_m;
        key_m = cur_key;
        cnt_m = exp_cnt;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc < 390) begin
                pt_valid  = ($urandom_range(0, 3) != 0);
                pt_in     = BW'($urandom);
                bit_ready = ($urandom_range(0, 3) != 0);
                key_load  = ($urandom_range(0, 15) == 0);
                key_in    = BW'($urandom);
            end else begin
                pt_valid = 1'b0; bit_ready = 1'b1; key_load = 1'b0;
            end
            #1;
            exp_valid = (beat_q.size() != 0);
            exp_ready = (beat_q.size() == 0) || (beat_q.size() == 1 && bit_ready);
            obs  = {bit_valid, pt_ready, bit_valid ? {pt_bit, k_bit, bit_first, bit_last} : 4'b0000};
            expv = {exp_valid, exp_ready, exp_valid ? beat_q[0] : 4'b0000};
            n_checks++; if (obs !== expv) $display("FAIL rand_beat cyc %0d: got %b expected %b", cyc, obs, expv); else n_pass++;
            n_checks++; if (blk_count !== CW'(cnt_m)) $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, blk_count, CW'(cnt_m)); else n_pass++;
            if (exp_valid && bit_ready) begin
                if (beat_q[0][0]) cnt_m++;
                void'(beat_q.pop_front());
            end
            if (pt_valid && exp_ready)
                for (int b = 0; b < BW; b++)
                    beat_q.push_back({pt_in[bit_pos(b)], key_m[bit_pos(b)], (b == 0), (b == BW - 1)});
            if (key_load) key_m = key_in;
            tick();
        end
        exp_cnt = cnt_m;
        cur_key = key_m;
    endtask

    task automatic test_reset_mid_block();
        pt_in = BW'($urandom); pt_valid = 1'b1; bit_ready = 1'b1;
        tick();
        pt_valid = 1'b0;
        for (int b = 0; b < 4; b++) tick();
        rst = 1'b1;
        #1;
        n_checks++; if (bit_valid !== 1'b1) $display("FAIL mid_block_active: got %b expected 1", bit_valid); else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bit_valid !== 1'b0) $display("FAIL rst_mid_bit_valid: got %b expected 0", bit_valid); else n_pass++;
        n_checks++; if (key_valid !== 1'b0) $display("FAIL rst_mid_key_valid: got %b expected 0", key_valid); else n_pass++;
        n_checks++; if (blk_count !== '0) $display("FAIL rst_mid_count: got %0d expected 0", blk_count); else n_pass++;
        n_checks++; if ({busy, pt_ready, pt_bit, k_bit} !== 4'b0000)
            $display("FAIL rst_mid_outputs: got %b expected 0000", {busy, pt_ready, pt_bit, k_bit}); else n_pass++;
        exp_cnt = 0;
    endtask

    task automatic test_wrap();
        logic [BW-1:0] kk, pt, pt_w, k_w;
        kk = BW'($urandom);
        key_in = kk; key_load = 1'b1; bit_ready = 1'b1;
        tick();
        key_load = 1'b0;
        for (int k = 0; k < (1 << CW); k++) begin
            pt = BW'($urandom);
            pt_in = pt; pt_valid = 1'b1;
            tick();
            pt_valid = 1'b0;
            for (int b = 0; b < BW; b++) begin
                #1;
                pt_w[bit_pos(b)] = pt_bit;
                k_w[bit_pos(b)]  = k_bit;
                tick();
            end
            n_checks++; if ({pt_w, k_w} !== {pt, kk}) $display("FAIL wrap_data blk %0d: got %h expected %h", k, {pt_w, k_w}, {pt, kk}); else n_pass++;
            n_checks++; if (blk_count !== CW'(k + 1)) $display("FAIL wrap_count blk %0d: got %0d expected %0d", k, blk_count, CW'(k + 1)); else n_pass++;
            if (k == (1 << CW) - 1) begin
                n_checks++; if (blk_count !== '0) $display("FAIL wrap_zero: got %0d expected 0", blk_count); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_key();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_key_reload();
        test_random();
        test_reset_mid_block();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ecb_bit_feeder.md
Name: ecb_bit_feeder

Overview:
- Upstream stage of the bit-serial ECB encryptor.
- Accepts whole plaintext blocks over a valid/ready handshake and holds a key register loaded separately.
- Streams the block and key one bit per transfer into the 1-bit XOR encryptor's PT/K inputs, with first/last framing and backpressure.
- Every block is encrypted with the same key until the key is reloaded (ECB).

Parameters:
- BLOCK_W, 8, plaintext block and key width in bits (>=2).
- MSB_FIRST, 1, 1 = bit BLOCK_W-1 is sent first; 0 = bit 0 is sent first.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- key_in  in  BLOCK_W  key value.
- key_load  in  1  one-cycle strobe; captures key_in.
- key_valid  out  1  a key has been loaded since reset.
- pt_in  in  BLOCK_W  plaintext block.
- pt_valid  in  1  pt_in is valid.
- pt_ready  out  1  block accepted when pt_valid && pt_ready.
- pt_bit  out  1  plaintext bit to the encryptor PT input.
- k_bit  out  1  key bit to the encryptor K input.
- bit_valid  out  1  pt_bit/k_bit are valid.
- bit_ready  in  1  downstream takes the bit when bit_valid && bit_ready.
- bit_first  out  1  current bit is the first of its block.
- bit_last  out  1  current bit is the last of its block.
- busy  out  1  a block is in flight.
- blk_count  out  CNT_W  blocks fully transferred, mod 2^CNT_W.

Behaviour:
- Reset:
  - state=IDLE; key_valid=0; bit_valid=0; bit_first=0; bit_last=0; busy=0; blk_count=0.
  - pt_bit=0, k_bit=0; key register and shift registers cleared.
  - A reset mid-block discards the block with no partial count. The key must be reloaded after reset.
- Key register:
  - key_load writes key_in at the next edge, in any state; key_valid goes to 1 and stays there.
  - A block latches a private copy of the registered key at acceptance.
  - A key_load in the same cycle as acceptance, or during shifting, affects only later blocks.
- pt_ready (combinational): key_valid && (state==IDLE || (state==SHIFT && bit_last && bit_ready)).
  - With no key loaded, pt_valid is ignored and stays pending.
- States:
  - IDLE: on acceptance, load pt_in into pt_sr, key copy into k_sr, bit index to 0; go to SHIFT.
  - SHIFT: bit_valid=1; pt_bit/k_bit = current bit of pt_sr/k_sr, selected per MSB_FIRST.
    - On transfer (bit_valid && bit_ready): advance the index.
    - If the index was BLOCK_W-1: blk_count += 1 (wraps), then reload if a new block is accepted the same cycle (stay in SHIFT), else go to IDLE.
- Latency:
  - Accept at edge N; first bit valid after edge N; bit i available no earlier than i cycles later.
  - Back-to-back blocks: BLOCK_W cycles per block with no bubble when bit_ready is held high.
- Backpressure: while bit_ready=0, pt_bit, k_bit, bit_first, bit_last and the index hold stable.
- Framing: bit_first=1 only at index 0; bit_last=1 only at index BLOCK_W-1; both are 0 when bit_valid=0.
- busy = (state==SHIFT).
- pt_bit/k_bit in IDLE hold the value from the last transfer; the consumer must qualify them with bit_valid.
- Index counter width is $clog2(BLOCK_W); no other arithmetic.

Decomposition:
- Shared package ecb_pkg: state enum (IDLE, SHIFT) and BLOCK_W default constant, for reuse by the matching downstream collector.
- Single module, no sub-module; the shift/select logic is small enough inline.

Test Plan:
- No key, pt_valid=1 with pt_in=8'hA5 for 10 cycles -> pt_ready=0, bit_valid=0, blk_count=0. Then key_load 8'h3C -> accepted next cycle.
- Key 8'h3C, pt 8'hA5, bit_ready=1, MSB_FIRST=1:
  - pt_bit sequence 1,0,1,0,0,1,0,1 and k_bit sequence 0,0,1,1,1,1,0,0.
  - bit_first on beat 0, bit_last on beat 7; blk_count=1; XOR of the streams = 8'h99.
- Back-to-back blocks 8'h00 then 8'hFF with pt_valid held -> 16 consecutive valid beats, no gap; pt_ready pulses on beat 7; blk_count=2.
- bit_ready toggled 1,0,0,1 pattern during a block -> outputs stable while low; all 8 bits delivered in order; count increments only on the last transfer.
- key_load 8'hF0 at beat 3 of a block using key 8'h3C -> that block's k_bit stream is still 8'h3C; the next block uses 8'hF0.
- rst asserted at beat 4 -> next cycle bit_valid=0, key_valid=0, blk_count=0; with blk_count preset near 2^CNT_W-1 and no reset, the count wraps to 0.
